// File: rtl/rd_active_vertex_single_pkg.sv
// Shared widths, FSM state encoding and vertex record for the active-vertex issue stages.
// Sibling issue stages import this package so they all agree on widths and states.
package rd_active_vertex_single_pkg;

  localparam int V_ID_WIDTH             = 32;
  localparam int V_VALUE_WIDTH          = 32;
  localparam int FIRST_EDGE_BRAM_AWIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    END   = 2'd3
  } issue_state_e;

  typedef struct packed {
    logic                     push_flag;
    logic [V_ID_WIDTH-1:0]    id;
    logic [V_VALUE_WIDTH-1:0] value;
  } vertex_t;

  // The low core_id_width bits pick the core, so they are stripped before the BRAM lookup.
  function automatic logic [FIRST_EDGE_BRAM_AWIDTH-1:0] vertex_edge_addr(
    input logic [V_ID_WIDTH-1:0] id,
    input int unsigned           core_id_width
  );
    logic [V_ID_WIDTH-1:0] shifted;
    shifted = id >> core_id_width;
    return shifted[FIRST_EDGE_BRAM_AWIDTH-1:0];
  endfunction

endpackage

// File: rtl/rd_active_vertex_single_if.sv
// Bus between the upstream scheduler, this issue stage and the first-edge read stage.
// The slave modport is the issue stage's view; master is the surrounding pipeline's view.
interface rd_active_vertex_single_if;
  import rd_active_vertex_single_pkg::*;

  logic                              front_push_flag;
  logic [V_ID_WIDTH-1:0]             front_active_v_id;
  logic [V_VALUE_WIDTH-1:0]          front_active_v_value;
  logic                              front_active_v_valid;
  logic                              front_iteration_end;
  logic                              front_iteration_end_valid;
  logic                              next_stage_full;
  logic                              stage_full;
  logic [FIRST_EDGE_BRAM_AWIDTH-1:0] rd_edge_addr;
  logic                              push_flag;
  logic [V_ID_WIDTH-1:0]             active_v_id;
  logic [V_VALUE_WIDTH-1:0]          active_v_value;
  logic                              rd_edge_valid;
  logic                              iteration_end;
  logic                              iteration_end_valid;

  modport slave (
    input  front_push_flag, front_active_v_id, front_active_v_value, front_active_v_valid,
    input  front_iteration_end, front_iteration_end_valid, next_stage_full,
    output stage_full, rd_edge_addr, push_flag, active_v_id, active_v_value,
    output rd_edge_valid, iteration_end, iteration_end_valid
  );

  modport master (
    output front_push_flag, front_active_v_id, front_active_v_value, front_active_v_valid,
    output front_iteration_end, front_iteration_end_valid, next_stage_full,
    input  stage_full, rd_edge_addr, push_flag, active_v_id, active_v_value,
    input  rd_edge_valid, iteration_end, iteration_end_valid
  );

endinterface

// File: rtl/rd_active_vertex_single_active_v_issue_fifo.sv
// Synchronous first-word-fall-through buffer for pending active vertices.
// Writes on full and reads on empty are ignored; prog_full is registered.
module active_v_issue_fifo #(
  parameter int WIDTH  = 65,
  parameter int AWIDTH = 5,
  parameter int MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              prog_full_o,
  output logic [AWIDTH:0]   count_o
);

  localparam int              DEPTH           = 1 << AWIDTH;
  localparam logic [AWIDTH:0] FULL_LEVEL      = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] PROG_FULL_LEVEL = (AWIDTH+1)'(DEPTH - MARGIN);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              prog_full_q;
  logic              wr_fire, rd_fire;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == FULL_LEVEL);
  assign prog_full_o = prog_full_q;
  assign count_o     = count_q;
  assign rd_data_o   = mem_q[rd_ptr_q];
  assign wr_fire     = wr_en_i && !full_o;
  assign rd_fire     = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AWIDTH'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + (AWIDTH+1)'(1);
      2'b01:   count_d = count_q - (AWIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // prog_full tracks next occupancy so it lines up with the count it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      prog_full_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      prog_full_q <= (count_d >= PROG_FULL_LEVEL);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/rd_active_vertex_single.sv
// Per-core issue stage: buffers active vertices and issues first-edge BRAM read requests,
// then holds iteration_end once everything accepted for the iteration has been issued.
module rd_active_vertex_single
  import rd_active_vertex_single_pkg::*;
#(
  parameter int CORE_ID_WIDTH    = 4,
  parameter int FIFO_AWIDTH      = 5,
  parameter int PROG_FULL_MARGIN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  rd_active_vertex_single_if.slave    bus,
  output logic                        overflow_err_o
);

  issue_state_e state_q, state_d;
  vertex_t      wr_vertex, head_vertex;
  logic         fifo_empty, fifo_full, fifo_prog_full;
  logic [FIFO_AWIDTH:0] fifo_count;
  logic         pop;
  logic         end_pending_q, end_pending_d;
  logic         overflow_q, overflow_d;
  logic         valid_q, valid_d;
  logic         push_flag_q, push_flag_d;
  logic [FIRST_EDGE_BRAM_AWIDTH-1:0] addr_q, addr_d;
  logic [V_ID_WIDTH-1:0]    id_q, id_d;
  logic [V_VALUE_WIDTH-1:0] value_q, value_d;

  assign wr_vertex = '{push_flag: bus.front_push_flag,
                       id:        bus.front_active_v_id,
                       value:     bus.front_active_v_value};

  active_v_issue_fifo #(
    .WIDTH  ($bits(vertex_t)),
    .AWIDTH (FIFO_AWIDTH),
    .MARGIN (PROG_FULL_MARGIN)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (bus.front_active_v_valid),
    .wr_data_i   (wr_vertex),
    .rd_en_i     (pop),
    .rd_data_o   (head_vertex),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .prog_full_o (fifo_prog_full),
    .count_o     (fifo_count)
  );

  assign pop = (state_q == ISSUE) && !fifo_empty && !bus.next_stage_full;

  // IDLE also wakes on an incoming write so the first vertex sees the same latency as the rest.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.front_active_v_valid || !fifo_empty || end_pending_q) state_d = ISSUE;
      ISSUE: if (end_pending_q && fifo_empty && !bus.front_active_v_valid) state_d = DRAIN;
      DRAIN: state_d = ((fifo_count == '0) && !bus.front_active_v_valid) ? END : ISSUE;
      END:   if (bus.front_active_v_valid) state_d = ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    end_pending_d = end_pending_q;
    if ((state_q == END) && (state_d != END)) end_pending_d = 1'b0;
    if (bus.front_iteration_end && bus.front_iteration_end_valid) end_pending_d = 1'b1;
    overflow_d  = overflow_q || (bus.front_active_v_valid && fifo_full);
    valid_d     = pop;
    push_flag_d = push_flag_q;
    addr_d      = addr_q;
    id_d        = id_q;
    value_d     = value_q;
    if (pop) begin
      push_flag_d = head_vertex.push_flag;
      addr_d      = vertex_edge_addr(head_vertex.id, CORE_ID_WIDTH);
      id_d        = head_vertex.id;
      value_d     = head_vertex.value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      end_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
      valid_q       <= 1'b0;
      push_flag_q   <= 1'b0;
      addr_q        <= '0;
      id_q          <= '0;
      value_q       <= '0;
    end else begin
      state_q       <= state_d;
      end_pending_q <= end_pending_d;
      overflow_q    <= overflow_d;
      valid_q       <= valid_d;
      push_flag_q   <= push_flag_d;
      addr_q        <= addr_d;
      id_q          <= id_d;
      value_q       <= value_d;
    end
  end

  // END is reachable only through DRAIN, so iteration_end never coincides with rd_edge_valid.
  assign bus.stage_full          = fifo_prog_full;
  assign bus.rd_edge_addr        = addr_q;
  assign bus.push_flag           = push_flag_q;
  assign bus.active_v_id         = id_q;
  assign bus.active_v_value      = value_q;
  assign bus.rd_edge_valid       = valid_q;
  assign bus.iteration_end       = (state_q == END);
  assign bus.iteration_end_valid = (state_q == END);
  assign overflow_err_o          = overflow_q;

endmodule

// File: doc/rd_active_vertex_single.md
Name: rd_active_vertex_single

Overview:
Per-core issue stage that drives the request side of the first-edge read stage.
- Accepts active vertices (id, value, push flag) from the upstream scheduler and buffers them.
- Converts each vertex id to a core-local first-edge BRAM address.
- Issues one request per cycle while the downstream stage_full is low.
- Holds iteration_end to the first-edge stage once everything accepted for the iteration has been issued.

Parameters:
V_ID_WIDTH, `V_ID_WIDTH, vertex id width
V_VALUE_WIDTH, `V_VALUE_WIDTH, vertex value width
FIRST_EDGE_BRAM_AWIDTH, `FIRST_EDGE_BRAM_AWIDTH, first-edge BRAM address width
CORE_ID_WIDTH, 4, log2 of `CORE_NUM; low id bits select the core
FIFO_AWIDTH, 5, log2 of internal buffer depth (default depth 32)
PROG_FULL_MARGIN, 4, free entries remaining when stage_full asserts

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
front_push_flag  in  1  push flag of incoming vertex
front_active_v_id  in  V_ID_WIDTH  incoming vertex id
front_active_v_value  in  V_VALUE_WIDTH  incoming vertex value
front_active_v_valid  in  1  incoming vertex strobe
front_iteration_end  in  1  upstream end-of-iteration level
front_iteration_end_valid  in  1  qualifier for front_iteration_end
next_stage_full  in  1  stage_full of the first-edge read stage
stage_full  out  1  buffer programmable-full, to upstream
rd_edge_addr  out  FIRST_EDGE_BRAM_AWIDTH  first-edge BRAM address
push_flag  out  1  push flag of issued vertex
active_v_id  out  V_ID_WIDTH  issued vertex id
active_v_value  out  V_VALUE_WIDTH  issued vertex value
rd_edge_valid  out  1  issue strobe
iteration_end  out  1  end-of-iteration level
iteration_end_valid  out  1  qualifier for iteration_end
overflow_err  out  1  sticky; a write was dropped on full

Behaviour:
- Reset values: all outputs 0; buffer empty; state IDLE; end_pending 0.
- Write path:
  - front_active_v_valid=1 writes {push_flag, id, value} when the buffer is not full.
  - When the buffer is full the write is dropped and overflow_err is set; it clears only on rst.
- stage_full = (occupancy >= 2^FIFO_AWIDTH - PROG_FULL_MARGIN), registered.
- Address: rd_edge_addr = id[CORE_ID_WIDTH +: FIRST_EDGE_BRAM_AWIDTH], truncating with no check.
- Issue (state ISSUE):
  - pop = !empty && !next_stage_full.
  - Outputs are registered. rd_edge_valid goes high the cycle after pop, for exactly one cycle per entry.
  - Latency from write to rd_edge_valid is 2 cycles when the buffer is empty and next_stage_full=0.
  - When rd_edge_valid=0, addr/id/value/push_flag hold their last values.
  - next_stage_full is honoured on the cycle sampled. The downstream programmable-full margin absorbs the one request in flight.
- end_pending:
  - Set when front_iteration_end && front_iteration_end_valid.
  - Cleared when the FSM leaves END.
- FSM:
  - IDLE -> ISSUE on buffer non-empty or end_pending.
  - ISSUE -> DRAIN when end_pending && empty.
  - DRAIN: one cycle that lets the last registered issue retire -> END.
  - END: iteration_end=iteration_end_valid=1 as a held level, because downstream only forwards it when its own buffer is empty.
  - END -> ISSUE on front_active_v_valid (new iteration). The level drops the same cycle.
- No iteration_end in any cycle where rd_edge_valid=1.
- Simultaneous write and pop: occupancy unchanged. Pointers wrap modulo depth.
- Simultaneous front end and write in ISSUE: the write is buffered first, so END waits for it to drain.
- rst mid-operation discards the buffer and any pending end, and returns to IDLE next cycle.

Decomposition:
- Widths come from accelerator.vh macros.
- FSM state localparams (IDLE/ISSUE/DRAIN/END) go in a shared include, acc_fsm.vh, for reuse by sibling issue stages.
- One sub-module, active_v_issue_fifo: synchronous first-word-fall-through FIFO, width 1+V_ID_WIDTH+V_VALUE_WIDTH. Provides empty, full, prog_full and occupancy.

Test Plan:
- Write ids 0x10, 0x21, 0x32 on consecutive cycles, next_stage_full=0 (CORE_ID_WIDTH=4) -> rd_edge_valid on cycles 2, 3, 4; addr 1, 2, 3; values and push_flags in order.
- Hold next_stage_full=1 for 10 cycles with 5 buffered -> no rd_edge_valid. After release, 5 consecutive strobes with no loss or duplication.
- Write 29 entries with no pops (depth 32, margin 4) -> stage_full=1 after occupancy reaches 28. Write 4 more -> overflow_err=1 and occupancy 32.
- Pulse front_iteration_end with 3 entries buffered -> iteration_end only after the 3rd rd_edge_valid plus the DRAIN cycle, held high. The next write drops it and issues normally.
- Front end and write in the same cycle with an empty buffer -> the vertex is issued first, then iteration_end.
- Assert rst mid-burst with 6 buffered -> all outputs 0 next cycle, no further rd_edge_valid, and overflow_err cleared.
